sha1_multi_core: RTL and testbench

Parametrised, time-interleaved SHA-1 compression core. It runs CHANNELS independent 512-bit block compressions round-robin through one shared round datapath. Message words stream in during rounds 0..15 with per-word flow control, rather than on a fixed external phase counter. Multi-block messages are chained per channel. It feeds the digest comparator stage of the search pipeline.

---
 rtl/sha1_pkg.sv | 64 ++++++
 rtl/sha1_round.sv | 38 +++
 rtl/sha1_multi_core.sv | 146 ++++++++++++++
 tb/tb_sha1_multi_core.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha1_pkg.sv
// Shared SHA-1 types, constants and round helper functions used by the
// interleaved compression core and its round datapath.
package sha1_pkg;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
    logic [31:0] e;
  } sha1_state_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } ch_fsm_t;

  localparam sha1_state_t H0 = '{
    a: 32'h67452301,
    b: 32'hEFCDAB89,
    c: 32'h98BADCFE,
    d: 32'h10325476,
    e: 32'hC3D2E1F0
  };

  localparam logic [31:0] K0 = 32'h5A827999;
  localparam logic [31:0] K1 = 32'h6ED9EBA1;
  localparam logic [31:0] K2 = 32'h8F1BBCDC;
  localparam logic [31:0] K3 = 32'hCA62C1D6;

  localparam logic [6:0] LAST_ROUND = 7'd79;
  localparam logic [6:0] FEED_ROUNDS = 7'd16;

  function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] f_ch(input logic [31:0] b, input logic [31:0] c,
                                       input logic [31:0] d);
    return (b & c) | (~b & d);
  endfunction

  function automatic logic [31:0] f_par(input logic [31:0] b, input logic [31:0] c,
                                        input logic [31:0] d);
    return b ^ c ^ d;
  endfunction

  function automatic logic [31:0] f_maj(input logic [31:0] b, input logic [31:0] c,
                                        input logic [31:0] d);
    return (b & c) | (b & d) | (c & d);
  endfunction

  // Word-wise mod 2^32 addition used for the final chaining step.
  function automatic sha1_state_t state_add(input sha1_state_t x, input sha1_state_t y);
    sha1_state_t s;
    s.a = x.a + y.a;
    s.b = x.b + y.b;
    s.c = x.c + y.c;
    s.d = x.d + y.d;
    s.e = x.e + y.e;
    return s;
  endfunction

endpackage

// File: rtl/sha1_round.sv
// One combinational SHA-1 round: selects f/K by round number and produces
// the next A..E. A single instance is time-shared by all channels.
module sha1_round
  import sha1_pkg::*;
(
  input  sha1_state_t i_state,
  input  logic [31:0] i_w,
  input  logic [6:0]  i_round,
  output sha1_state_t o_state
);

  logic [31:0] w_f;
  logic [31:0] w_k;
  logic [31:0] w_temp;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_f = f_par(i_state.b, i_state.c, i_state.d);
    w_k = K3;
    if (i_round < 7'd20) begin
      w_f = f_ch(i_state.b, i_state.c, i_state.d);
      w_k = K0;
    end else if (i_round < 7'd40) begin
      w_k = K1;
    end else if (i_round < 7'd60) begin
      w_f = f_maj(i_state.b, i_state.c, i_state.d);
      w_k = K2;
    end

    w_temp    = rotl(i_state.a, 5) + w_f + i_state.e + w_k + i_w;
    o_state.a = w_temp;
    o_state.b = i_state.a;
    o_state.c = rotl(i_state.b, 30);
    o_state.d = i_state.c;
    o_state.e = i_state.d;
  end

endmodule

// File: rtl/sha1_multi_core.sv
// Time-interleaved SHA-1 compression core: CHANNELS contexts share one round
// datapath round-robin; words 0..15 are fed with per-word flow control.
module sha1_multi_core
  import sha1_pkg::*;
#(
  parameter  int CHANNELS = 4,
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [CH_W-1:0] slot,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_first,
  input  logic [31:0]     in_word,
  output logic            out_valid,
  output logic [CH_W-1:0] out_channel,
  output logic [159:0]    out_digest
);

  // Arrays span the full slot index range so any slot value is a legal index.
  localparam int              NSLOT     = 1 << CH_W;
  localparam logic [CH_W-1:0] LAST_SLOT = CH_W'(CHANNELS - 1);

  logic [CH_W-1:0] r_slot;
  ch_fsm_t         r_fsm   [NSLOT];
  logic [6:0]      r_round [NSLOT];
  sha1_state_t     r_ctx   [NSLOT];
  sha1_state_t     r_chain [NSLOT];
  logic [31:0]     r_w     [NSLOT][16];

  logic            r_out_valid;
  logic [CH_W-1:0] r_out_channel;
  sha1_state_t     r_out_digest;

  ch_fsm_t     w_fsm;
  ch_fsm_t     w_fsm_nxt;
  logic [6:0]  w_round;
  logic [6:0]  w_round_nxt;
  logic [3:0]  w_widx;
  logic        w_idle;
  logic        w_feed;
  logic        w_fire;
  logic        w_last;
  logic [31:0] w_word;
  sha1_state_t w_chain_sel;
  sha1_state_t w_round_in;
  sha1_state_t w_round_out;
  sha1_state_t w_digest;

  // Datapath view of the channel that owns this cycle.
  always_comb begin
    w_fsm    = r_fsm[r_slot];
    w_round  = r_round[r_slot];
    w_idle   = (w_fsm == ST_IDLE);
    w_widx   = w_round[3:0];
    w_feed   = w_idle || (w_round < FEED_ROUNDS);
    in_ready = w_feed;
    w_fire   = w_feed ? in_valid : 1'b1;
    w_last   = (w_round == LAST_ROUND);

    // in_first only matters when the block starts; afterwards the latched chain is used.
    w_chain_sel = (w_idle && in_first) ? H0 : r_chain[r_slot];
    w_round_in  = w_idle ? w_chain_sel : r_ctx[r_slot];

    // Window is circular: slot t mod 16 still holds W[t-16] until it is overwritten.
    w_word = w_feed ? in_word
                    : rotl(r_w[r_slot][w_widx - 4'd3] ^ r_w[r_slot][w_widx - 4'd8] ^
                           r_w[r_slot][w_widx - 4'd14] ^ r_w[r_slot][w_widx], 1);

    w_digest = state_add(w_chain_sel, w_round_out);
  end

  sha1_round u_round (
    .i_state (w_round_in),
    .i_w     (w_word),
    .i_round (w_round),
    .o_state (w_round_out)
  );

  // Per-channel FSM next state; stalls leave state and round untouched.
  always_comb begin
    w_fsm_nxt   = w_fsm;
    w_round_nxt = w_round;
    if (w_fire) begin
      if (w_last) begin
        w_fsm_nxt   = ST_IDLE;
        w_round_nxt = 7'd0;
      end else begin
        w_fsm_nxt   = ST_BUSY;
        w_round_nxt = w_round + 7'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
      r_slot <= '0;
      for (int i = 0; i < NSLOT; i++) begin
        r_fsm[i]   <= ST_IDLE;
        r_round[i] <= 7'd0;
      end
    end else begin
      r_slot          <= (r_slot == LAST_SLOT) ? '0 : r_slot + CH_W'(1);
      r_fsm[r_slot]   <= w_fsm_nxt;
      r_round[r_slot] <= w_round_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the W windows are reset along with the contexts, so they must be flops rather than reset-less RAM.
      for (int i = 0; i < NSLOT; i++) begin
        r_ctx[i]   <= '0;
        r_chain[i] <= H0;
        for (int j = 0; j < 16; j++) begin
          r_w[i][j] <= '0;
        end
      end
      r_out_valid   <= 1'b0;
      r_out_channel <= '0;
      r_out_digest  <= '0;
    end else begin
      r_out_valid <= w_fire && w_last;
      if (w_fire) begin
        r_ctx[r_slot]         <= w_round_out;
        r_w[r_slot][w_widx]   <= w_word;
        if (w_idle) begin
          r_chain[r_slot] <= w_chain_sel;
        end
        if (w_last) begin
          r_chain[r_slot] <= w_digest;
          r_out_channel   <= r_slot;
          r_out_digest    <= w_digest;
        end
      end
    end
  end

  assign slot        = r_slot;
  assign out_valid   = r_out_valid;
  assign out_channel = r_out_channel;
  assign out_digest  = r_out_digest;

endmodule

// File: tb/tb_sha1_multi_core.sv
// Bench for sha1_multi_core: a 1-channel and a 4-channel instance driven from
// a whole-block SHA-1 model plus a per-channel schedule model.
module tb_sha1_multi_core;

  typedef logic [31:0] blk_t [16];
  typedef struct {
    int           cyc;
    int           ch;
    logic [159:0] dig;
  } ev_t;

  localparam logic [159:0] TB_H0  = 160'h67452301_efcdab89_98badcfe_10325476_c3d2e1f0;
  localparam logic [159:0] D_ABC  = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
  localparam logic [159:0] D_EMPT = 160'hda39a3ee_5e6b4b0d_3255bfef_95601890_afd80709;
  localparam logic [159:0] D_TWO  = 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1_n = 1'b0, rst4_n = 1'b0;
  logic v1 = 1'b0, f1 = 1'b0, v4 = 1'b0, f4 = 1'b0;
  logic [31:0] w1 = '0, w4 = '0;
  logic [0:0] slot1, oc1;
  logic [1:0] slot4, oc4;
  logic rdy1, rdy4, ov1, ov4;
  logic [159:0] od1, od4;

  sha1_multi_core #(.CHANNELS(1)) u_dut1 (
    .clk(clk), .rst_n(rst1_n), .slot(slot1), .in_valid(v1), .in_ready(rdy1),
    .in_first(f1), .in_word(w1), .out_valid(ov1), .out_channel(oc1), .out_digest(od1)
  );

  sha1_multi_core #(.CHANNELS(4)) u_dut4 (
    .clk(clk), .rst_n(rst4_n), .slot(slot4), .in_valid(v4), .in_ready(rdy4),
    .in_first(f4), .in_word(w4), .out_valid(ov4), .out_channel(oc4), .out_digest(od4)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ev_t q1[$], q4[$];
  always @(negedge clk) begin
    if (ov1 === 1'b1) q1.push_back('{cyc, int'(oc1), od1});
    if (ov4 === 1'b1) q4.push_back('{cyc, int'(oc4), od4});
  end

  int vectors = 0, miscompares = 0;
  int rel[2];
  logic [159:0] m_chain[2][4];
  blk_t j_blk[4];
  bit j_first[4], j_act[4], j_noise[4];
  int j_idx[4], j_rd[4], j_gap[4], j_t0[4], j_stall[4];
  logic [159:0] j_exp[4], got[4];

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // Full SHA-1 compression of one block with the whole 80-word schedule expanded up front.
  function automatic logic [159:0] ref_compress(input logic [159:0] h, input blk_t m);
    logic [31:0] w[80];
    logic [31:0] a, b, c, d, e, f, k, t;
    for (int i = 0; i < 80; i++)
      w[i] = (i < 16) ? m[i] : rl(w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16], 1);
    {a, b, c, d, e} = h;
    for (int i = 0; i < 80; i++) begin
      if (i < 20)      begin f = (b & c) | (~b & d);          k = 32'h5a827999; end
      else if (i < 40) begin f = b ^ c ^ d;                   k = 32'h6ed9eba1; end
      else if (i < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8f1bbcdc; end
      else             begin f = b ^ c ^ d;                   k = 32'hca62c1d6; end
      t = rl(a, 5) + f + e + k + w[i];
      e = d; d = c; c = rl(b, 30); b = a; a = t;
    end
    return {h[159:128] + a, h[127:96] + b, h[95:64] + c, h[63:32] + d, h[31:0] + e};
  endfunction

  function automatic logic [159:0] get_slot(input int dut);
    return (dut == 0) ? 160'(slot1) : 160'(slot4);
  endfunction

  function automatic logic [159:0] get_ready(input int dut);
    return (dut == 0) ? 160'(rdy1) : 160'(rdy4);
  endfunction

  function automatic int qsize(input int dut);
    return (dut == 0) ? q1.size() : q4.size();
  endfunction

  task automatic drive(input int dut, input logic v, input logic f, input logic [31:0] w);
    if (dut == 0) begin v1 = v; f1 = f; w1 = w; end
    else          begin v4 = v; f4 = f; w4 = w; end
  endtask

  task automatic pop_ev(input int dut, input int ch, output bit found, output ev_t e);
    found = 0;
    e = '{0, 0, '0};
    if (dut == 0) begin
      for (int i = 0; i < q1.size(); i++)
        if (!found && q1[i].ch == ch) begin e = q1[i]; q1.delete(i); found = 1; end
    end else begin
      for (int i = 0; i < q4.size(); i++)
        if (!found && q4[i].ch == ch) begin e = q4[i]; q4.delete(i); found = 1; end
    end
  endtask

  task automatic do_reset(input int dut);
    if (dut == 0) rst1_n = 1'b0; else rst4_n = 1'b0;
    drive(dut, 1'b0, 1'b0, '0);
    #1;
    check($sformatf("rst_out_valid_d%0d", dut), (dut == 0) ? 160'(ov1) : 160'(ov4), 160'(0));
    check($sformatf("rst_out_channel_d%0d", dut), (dut == 0) ? 160'(oc1) : 160'(oc4), 160'(0));
    check($sformatf("rst_out_digest_d%0d", dut), (dut == 0) ? od1 : od4, 160'(0));
    check($sformatf("rst_slot_d%0d", dut), get_slot(dut), 160'(0));
    check($sformatf("rst_in_ready_d%0d", dut), get_ready(dut), 160'(1));
    repeat (3) @(posedge clk);
    #1;
    if (dut == 0) rst1_n = 1'b1; else rst4_n = 1'b1;
    rel[dut] = cyc;
    for (int ch = 0; ch < 4; ch++) begin
      m_chain[dut][ch] = TB_H0;
      j_act[ch] = 0; j_rd[ch] = 0; j_idx[ch] = 0;
    end
    check($sformatf("no_out_through_reset_d%0d", dut), 160'(qsize(dut)), 160'(0));
  endtask

  task automatic add_job(input int dut, input int ch, input bit first, input blk_t blk,
                         input int gap, input bit noise);
    j_blk[ch]   = blk;
    j_first[ch] = first;
    j_exp[ch]   = ref_compress(first ? TB_H0 : m_chain[dut][ch], blk);
    m_chain[dut][ch] = j_exp[ch];
    j_act[ch] = 1; j_idx[ch] = 0; j_rd[ch] = 0; j_stall[ch] = 0;
    j_gap[ch] = gap; j_noise[ch] = noise;
  endtask

  // Steps every cycle: owner slot follows the cycle count since reset release; a
  // channel executes one round per owned slot unless it skips a word in rounds 1..15.
  task automatic run_jobs(input int dut, input int stop_round, input int max_cyc);
    int c, n, s;
    bit all_done, tout, found;
    ev_t e;
    c = (dut == 0) ? 1 : 4;
    n = 0;
    tout = 0;
    forever begin
      all_done = 1;
      for (int ch = 0; ch < c; ch++) if (j_act[ch] && j_rd[ch] < 80) all_done = 0;
      if (all_done) break;
      if (n >= max_cyc) begin tout = 1; break; end
      @(posedge clk);
      #1;
      n++;
      s = (cyc - rel[dut]) % c;
      check($sformatf("slot_d%0d", dut), get_slot(dut), 160'(s));
      check($sformatf("in_ready_d%0d_ch%0d", dut, s), get_ready(dut),
            160'(!j_act[s] || j_rd[s] < 16 || j_rd[s] >= 80));
      drive(dut, 1'b0, 1'($urandom_range(1)), $urandom);
      if (stop_round >= 0 && s == 0 && j_rd[0] == stop_round) return;
      if (j_act[s] && j_idx[s] < 16) begin
        if (j_idx[s] > 0 && $urandom_range(99) < j_gap[s]) begin
          j_stall[s]++;
        end else begin
          if (j_idx[s] == 0) j_t0[s] = cyc;
          drive(dut, 1'b1, (j_idx[s] == 0) ? j_first[s] : 1'($urandom_range(1)), j_blk[s][j_idx[s]]);
          j_idx[s]++;
          j_rd[s]++;
        end
      end else if (j_act[s] && j_rd[s] < 80) begin
        if (j_noise[s] && $urandom_range(1) == 1) drive(dut, 1'b1, 1'($urandom_range(1)), $urandom);
        j_rd[s]++;
      end
    end
    drive(dut, 1'b0, 1'b0, '0);
    repeat (3) @(negedge clk);
    check($sformatf("timeout_d%0d", dut), 160'(tout), 160'(0));
    for (int ch = 0; ch < c; ch++) begin
      if (j_act[ch]) begin
        pop_ev(dut, ch, found, e);
        check($sformatf("out_present_d%0d_ch%0d", dut, ch), 160'(found), 160'(1));
        if (found) begin
          got[ch] = e.dig;
          check($sformatf("digest_d%0d_ch%0d", dut, ch), e.dig, j_exp[ch]);
          check($sformatf("latency_d%0d_ch%0d", dut, ch), 160'(e.cyc),
                160'(j_t0[ch] + 79 * c + 1 + j_stall[ch] * c));
        end
        j_act[ch] = 0;
      end
    end
    check($sformatf("extra_out_d%0d", dut), 160'(qsize(dut)), 160'(0));
  endtask

  initial begin
    blk_t abc_blk, empty_blk, two_a, two_b, rnd;
    abc_blk   = '{default: '0};
    empty_blk = '{default: '0};
    two_b     = '{default: '0};
    abc_blk[0]   = 32'h61626380;
    abc_blk[15]  = 32'h00000018;
    empty_blk[0] = 32'h80000000;
    two_a = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
              32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
              32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
              32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    two_b[15] = 32'h000001c0;

    do_reset(0);
    do_reset(1);

    // Single channel "abc": out_valid must land exactly 80 cycles after word 0.
    add_job(0, 0, 1'b1, abc_blk, 0, 1'b0);
    run_jobs(0, -1, 2000);
    check("abc_c1_known", got[0], D_ABC);

    // Four channels: empty message on channel 2 alongside "abc" on channel 0.
    add_job(1, 0, 1'b1, abc_blk, 0, 1'b0);
    add_job(1, 2, 1'b1, empty_blk, 0, 1'b0);
    run_jobs(1, -1, 4000);
    check("abc_c4_known", got[0], D_ABC);
    check("empty_c4_known", got[2], D_EMPT);

    // Two-block message chained through the channel's own digest.
    add_job(0, 0, 1'b1, two_a, 0, 1'b1);
    run_jobs(0, -1, 2000);
    add_job(0, 0, 1'b0, two_b, 0, 1'b1);
    run_jobs(0, -1, 2000);
    check("two_block_known", got[0], D_TWO);

    // Random blocks, random feed gaps and ignored words during rounds 16..79.
    for (int it = 0; it < 3; it++) begin
      for (int ch = 0; ch < 4; ch++) begin
        for (int i = 0; i < 16; i++) rnd[i] = $urandom;
        add_job(1, ch, 1'($urandom_range(1)), rnd, 35, 1'b1);
      end
      run_jobs(1, -1, 8000);
      for (int i = 0; i < 16; i++) rnd[i] = $urandom;
      add_job(0, 0, 1'($urandom_range(1)), rnd, 35, 1'b1);
      run_jobs(0, -1, 4000);
    end

    // Reset in the middle of a block: nothing emitted, chain falls back to H0.
    for (int i = 0; i < 16; i++) rnd[i] = $urandom;
    add_job(0, 0, 1'b0, rnd, 20, 1'b1);
    run_jobs(0, 40, 4000);
    do_reset(0);
    add_job(0, 0, 1'b0, abc_blk, 0, 1'b0);
    run_jobs(0, -1, 2000);
    check("chain_from_h0_after_reset", got[0], D_ABC);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
